multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// - Multi-cycle sequencer for the RV32I core datapath: FETCH/DECODE/EXECUTE/MEM/WB states.
// - Drives all datapath selects and strobes (PC, IR, register file, ALU, data memory).
// - Handshakes with a variable-latency unified memory and traps on illegal opcodes or memory timeout.
// - Supports lw, sw, R-type (add/sub/and/or/slt), I-ALU (addi/andi/ori/slti), beq, bne, jal, lui.
// PARAMETERS
// - WIDTH        32  width of the retired-instruction counter
// - MEM_TIMEOUT  16  max cycles mem_req may wait for mem_ready before trap (>=2)
// PORTS
// - clk          in   1      clock, rising edge
// - rst          in   1      asynchronous, active-low reset
// - op           in   7      IR[6:0]
// - funct3       in   3      IR[14:12]
// - funct7b5     in   1      IR[30]
// - Zero         in   1      ALU zero flag
// - mem_ready    in   1      memory completes the current access this cycle
// - mem_req      out  1      memory access request (fetch, load or store)
// - MemWrite     out  1      store strobe (with mem_req)
// - AdrSrc       out  1      0 = PC, 1 = ALUOut drives memory address
// - IRWrite      out  1      latch instruction and OldPC
// - PCWrite      out  1      PC <= Result
// - RegWrite     out  1      register file write enable
// - ResultSrc    out  2      00 = ALUOut, 01 = Data, 10 = ALUResult
// - ALUSrcA      out  2      00 = PC, 01 = OldPC, 10 = RD1, 11 = zero
// - ALUSrcB      out  2      00 = RD2, 01 = ImmExt, 10 = const 4
// - ImmSrc       out  3      000 = I, 001 = S, 010 = B, 011 = J, 100 = U
// - ALUControl   out  3      000 add, 001 sub, 010 and, 011 or, 101 slt
// - trap         out  1      sticky fault flag
// - trap_cause   out  2      01 = illegal opcode, 10 = memory timeout
// - instret      out  WIDTH  retired-instruction count, wraps modulo 2^WIDTH
// BEHAVIOUR
// - Reset (rst == 0):
//   - State goes to FETCH.
//   - trap, trap_cause, instret and the timeout counter clear to 0.
//   - All strobes (mem_req, MemWrite, IRWrite, PCWrite, RegWrite) are forced 0 while rst is low.
// - Moore outputs are decoded from state; PCWrite is also qualified by mem_ready / Zero as listed.
// - FETCH:
//   - mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, add, ResultSrc = 10.
//   - IRWrite = PCWrite = mem_ready.
//   - Stays in FETCH until mem_ready, then goes to DECODE.
// - DECODE: ALUSrcA = 01, ALUSrcB = 01, ImmSrc = B, add (branch target into ALUOut).
//   Next state by op:
//   - 0000011 / 0100011 -> MEMADR
//   - 0110011 -> EXEC_R
//   - 0010011 -> EXEC_I
//   - 1100011 -> BRANCH
//   - 1101111 -> JAL
//   - 0110111 -> LUI
//   - anything else -> TRAP, cause 01
// - MEMADR: ALUSrcA = 10, ALUSrcB = 01, ImmSrc = I (lw) or S (sw), add.
//   Goes to MEMREAD for lw, MEMWRITE for sw.
// - MEMREAD: mem_req = 1, AdrSrc = 1. Waits for mem_ready, then MEMWB.
// - MEMWB: ResultSrc = 01, RegWrite = 1 -> FETCH.
// - MEMWRITE: mem_req = MemWrite = 1, AdrSrc = 1. Waits for mem_ready, then FETCH.
// - EXEC_R / EXEC_I:
//   - ALUSrcA = 10, ALUSrcB = 00 (R) or 01 (I, ImmSrc = I).
//   - ALUControl from the funct decode; then ALUWB.
//   - funct7b5 selects sub only for R-type.
//   - Unsupported funct3 -> TRAP, cause 01.
// - ALUWB: ResultSrc = 00, RegWrite = 1 -> FETCH.
// - BRANCH: ALUSrcA = 10, ALUSrcB = 00, sub, ResultSrc = 00.
//   - PCWrite = Zero for beq (funct3 000), !Zero for bne (funct3 001).
//   - Other funct3 -> TRAP, cause 01. Otherwise -> FETCH.
// - JAL:
//   - ALUSrcA = 01, ALUSrcB = 10, add; ResultSrc = 00 writes the link (old PC+4 from ALUOut) to rd.
//   - In the same cycle PC is loaded with the target: PCWrite = 1, ImmSrc = J. -> FETCH.
// - LUI: ALUSrcA = 11, ALUSrcB = 01, ImmSrc = U, add -> ALUWB.
// - Latency with mem_ready = 1 immediately:
//   - lw 5 cycles; sw 4; R-type, I-ALU, lui 4; jal 3; beq/bne 3.
// - instret increments on the cycle that leaves MEMWB, MEMWRITE (with ready), ALUWB, BRANCH or JAL.
// - Timeout counter:
//   - Counts each cycle mem_req = 1 && mem_ready = 0; clears when mem_ready = 1 or in non-memory states.
//   - On reaching MEM_TIMEOUT: go to TRAP, cause 10; no strobe is asserted that cycle.
// - TRAP: all strobes 0, trap = 1. Held until reset (terminal).
//   If both causes arise in one cycle, illegal (01) wins.
// - Reset mid-access: mem_req drops asynchronously; no partial write or IRWrite is issued.
// STRUCTURE
// - Package riscv_ctrl_pkg:
//   - state_t enum;
//   - opcode localparams;
//   - ALUControl, ImmSrc, ALUSrcA/B and ResultSrc encodings;
//   - trap cause codes.
// - Sub-module alu_decoder: combinational (alu_op class, funct3, funct7b5) -> ALUControl, illegal flag.
// - FSM, timeout counter and instret counter stay in this module.
// TESTING
// - lw, ready immediate: exactly 5 cycles.
//   - FETCH asserts mem_req, IRWrite, PCWrite; MEMREAD has AdrSrc = 1; MEMWB has RegWrite = 1, ResultSrc = 01.
//   - instret 0 -> 1.
// - add (op 0110011, funct3 000, funct7b5 0) then sub (funct7b5 1): EXEC_R shows ALUControl 000 then 001.
// - beq, Zero = 1 -> PCWrite = 1 in BRANCH; beq, Zero = 0 -> PCWrite = 0. bne inverts both.
// - op 1111111 -> TRAP after DECODE: trap = 1, trap_cause = 01, all strobes 0 for 20 cycles.
// - FETCH with mem_ready held 0, MEM_TIMEOUT = 16 -> TRAP on the 16th wait cycle, cause 10.
//   Ready on the 15th cycle -> no trap.
// - rst pulled low during MEMWRITE wait -> MemWrite and mem_req drop immediately.
//   - After release: FETCH, instret = 0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
package riscv_ctrl_pkg;

   // Sequencer states; the encoding itself carries no meaning
   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_LUI,
      S_TRAP
   } state_t;

   // Operation class handed to the ALU decoder
   typedef enum logic [1:0] {
      ALUOP_ADD,
      ALUOP_SUB,
      ALUOP_RTYPE,
      ALUOP_ITYPE
   } alu_op_t;

   // Major opcodes (IR[6:0])
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // funct3 values the core understands
   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   // ALUControl encodings
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Immediate format selects
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // ALU operand selects
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCA_ZERO  = 2'b11;
   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   // Result bus selects
   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_DATA      = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   // Trap cause codes
   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   // States in which the unified memory is being accessed
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an operation class plus funct fields onto ALUControl and flags
// funct3 values the core does not implement.
module alu_decoder
   import riscv_ctrl_pkg::*;
(
   input  alu_op_t    alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   output logic [2:0] alu_control,
   output logic       illegal
);

   // funct7b5 only turns add into sub for register-register ops; addi ignores it
   always_comb begin
      alu_control = ALU_ADD;
      illegal     = 1'b0;
      case (alu_op)
         ALUOP_ADD: alu_control = ALU_ADD;
         ALUOP_SUB: alu_control = ALU_SUB;
         ALUOP_RTYPE, ALUOP_ITYPE: begin
            case (funct3)
               F3_ADD:  alu_control = ((alu_op == ALUOP_RTYPE) && funct7b5) ? ALU_SUB : ALU_ADD;
               F3_SLT:  alu_control = ALU_SLT;
               F3_OR:   alu_control = ALU_OR;
               F3_AND:  alu_control = ALU_AND;
               default: illegal = 1'b1;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the RV32I datapath: fetch/decode/execute/memory/
// writeback, memory handshake with timeout, illegal-opcode trap, retire count.
module multicycle_control_fsm
   import riscv_ctrl_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int MEM_TIMEOUT = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       op,
   input  logic [2:0]       funct3,
   input  logic             funct7b5,
   input  logic             Zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             MemWrite,
   output logic             AdrSrc,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [2:0]       ImmSrc,
   output logic [2:0]       ALUControl,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic [WIDTH-1:0] instret
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);

   state_t       state;
   state_t       state_next;
   logic [TW-1:0] tmo_cnt;
   alu_op_t      alu_op;
   logic         dec_illegal;
   logic         mem_wait;
   logic         tmo_hit;
   logic         illegal_now;
   logic         retire;
   logic         req_int;
   logic         memwrite_int;
   logic         irwrite_int;
   logic         pcwrite_int;
   logic         regwrite_int;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .alu_control (ALUControl),
      .illegal     (dec_illegal)
   );

   // A memory access that has waited MEM_TIMEOUT cycles is abandoned on its last wait cycle
   always_comb begin
      mem_wait = is_mem_state(state) && !mem_ready;
      tmo_hit  = mem_wait && (tmo_cnt == TW'(MEM_TIMEOUT - 1));
   end

   // Moore decode of datapath selects; strobes are gated by rst so they drop at once on reset
   always_comb begin
      req_int      = 1'b0;
      memwrite_int = 1'b0;
      irwrite_int  = 1'b0;
      pcwrite_int  = 1'b0;
      regwrite_int = 1'b0;
      AdrSrc       = 1'b0;
      ResultSrc    = RES_ALUOUT;
      ALUSrcA      = SRCA_PC;
      ALUSrcB      = SRCB_RD2;
      ImmSrc       = IMM_I;
      alu_op       = ALUOP_ADD;
      case (state)
         S_FETCH: begin
            req_int     = 1'b1;
            irwrite_int = mem_ready;
            pcwrite_int = mem_ready;
            ALUSrcB     = SRCB_FOUR;
            ResultSrc   = RES_ALURESULT;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_B;
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = (op == OP_LOAD) ? IMM_I : IMM_S;
         end
         S_MEMREAD: begin
            req_int = 1'b1;
            AdrSrc  = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc    = RES_DATA;
            regwrite_int = 1'b1;
         end
         S_MEMWRITE: begin
            req_int      = 1'b1;
            memwrite_int = 1'b1;
            AdrSrc       = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_RTYPE;
         end
         S_EXEC_I: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_I;
            alu_op  = ALUOP_ITYPE;
         end
         S_ALUWB: begin
            regwrite_int = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_RD2;
            alu_op  = ALUOP_SUB;
            if (funct3 == F3_BEQ)
               pcwrite_int = Zero;
            else if (funct3 == F3_BNE)
               pcwrite_int = !Zero;
         end
         S_JAL: begin
            ALUSrcA      = SRCA_OLDPC;
            ALUSrcB      = SRCB_FOUR;
            ImmSrc       = IMM_J;
            regwrite_int = 1'b1;
            pcwrite_int  = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = SRCA_ZERO;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = IMM_U;
         end
         default: ;
      endcase
      mem_req  = rst & req_int;
      MemWrite = rst & memwrite_int;
      IRWrite  = rst & irwrite_int;
      PCWrite  = rst & pcwrite_int;
      RegWrite = rst & regwrite_int;
   end

   // Next state, illegal detection and retirement, before trap override
   always_comb begin
      state_next  = state;
      illegal_now = 1'b0;
      retire      = 1'b0;
      case (state)
         S_FETCH:    if (mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXEC_R;
               OP_ITYPE:          state_next = S_EXEC_I;
               OP_BRANCH:         state_next = S_BRANCH;
               OP_JAL:            state_next = S_JAL;
               OP_LUI:            state_next = S_LUI;
               default:           illegal_now = 1'b1;
            endcase
         end
         S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  if (mem_ready) state_next = S_MEMWB;
         S_MEMWB: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_MEMWRITE: begin
            if (mem_ready) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I: begin
            if (dec_illegal)
               illegal_now = 1'b1;
            else
               state_next = S_ALUWB;
         end
         S_ALUWB, S_JAL: begin
            state_next = S_FETCH;
            retire     = 1'b1;
         end
         S_BRANCH: begin
            if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
               state_next = S_FETCH;
               retire     = 1'b1;
            end else begin
               illegal_now = 1'b1;
            end
         end
         S_LUI:      state_next = S_ALUWB;
         S_TRAP:     state_next = S_TRAP;
         default:    state_next = S_FETCH;
      endcase
   end

   // State, sticky trap, wait counter and retire counter; illegal wins over timeout
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_FETCH;
         trap       <= 1'b0;
         trap_cause <= CAUSE_NONE;
         tmo_cnt    <= '0;
         instret    <= '0;
      end else begin
         tmo_cnt <= mem_wait ? tmo_cnt + 1'b1 : '0;
         if (retire)
            instret <= instret + 1'b1;
         if (illegal_now) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_ILLEGAL;
         end else if (tmo_hit) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= CAUSE_TIMEOUT;
         end else begin
            state <= state_next;
         end
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for the multi-cycle control unit: directed scenarios
// plus a randomized instruction stream against a per-phase reference model.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [6:0]  op = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7b5 = 1'b0;
   logic        Zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, trap_cause;
   logic [2:0]  ImmSrc, ALUControl;
   logic        trap;
   logic [31:0] instret;

   int assert_count = 0;
   int fail_count   = 0;

   wire [4:0] strobes = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite};

   multicycle_control_fsm #(.WIDTH(32), .MEM_TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .op         (op),
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .Zero       (Zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .MemWrite   (MemWrite),
      .AdrSrc     (AdrSrc),
      .IRWrite    (IRWrite),
      .PCWrite    (PCWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ImmSrc     (ImmSrc),
      .ALUControl (ALUControl),
      .trap       (trap),
      .trap_cause (trap_cause),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   // Expected behaviour of one clock cycle; chk_* flags mark fields that matter there
   typedef struct {
      logic        ready;
      logic [4:0]  strb;
      bit          chk_alu;
      logic [2:0]  alu;
      bit          chk_sel;
      logic [3:0]  sel;
      bit          chk_imm;
      logic [2:0]  imm;
      bit          chk_res;
      logic [1:0]  res;
      bit          chk_adr;
      logic        adr;
      bit          chk_ret;
      logic [31:0] ret;
   } cyc_t;

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mem_ready = 1'b0;
      Zero = 1'b0;
      op = '0;
      funct3 = '0;
      funct7b5 = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      mem_ready = 1'b1;
      op = 7'b0110011;
      repeat (2) @(posedge clk);
      settle();
      assert_count++;
      if (strobes !== 5'b00000) begin
         fail_count++;
         $display("[TB] FAIL reset_strobes: got %b, required 00000", strobes);
      end
      assert_count++;
      if (trap !== 1'b0 || trap_cause !== 2'b00 || instret !== 32'd0) begin
         fail_count++;
         $display("[TB] FAIL reset_state: trap=%b cause=%b instret=%0d, required 0/00/0", trap, trap_cause, instret);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      settle();
      assert_count++;
      if (strobes !== 5'b10110) begin
         fail_count++;
         $display("[TB] FAIL reset_release_fetch: strobes=%b, required 10110", strobes);
      end
   endtask

   task automatic test_lw();
      do_reset();
      op = 7'b0000011;
      funct3 = 3'b010;
      mem_ready = 1'b1;
      settle();
      assert_count++;
      if (strobes !== 5'b10110 || AdrSrc !== 1'b0 || ResultSrc !== 2'b10 || instret !== 32'd0) begin
         fail_count++;
         $display("[TB] FAIL lw_fetch: strobes=%b adr=%b res=%b instret=%0d, required 10110/0/10/0", strobes, AdrSrc, ResultSrc, instret);
      end
      advance(); settle();
      assert_count++;
      if (strobes !== 5'b00000 || ImmSrc !== 3'b010) begin
         fail_count++;
         $display("[TB] FAIL lw_decode: strobes=%b imm=%b, required 00000/010", strobes, ImmSrc);
      end
      advance(); settle();
      assert_count++;
      if (strobes !== 5'b00000 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01 || ImmSrc !== 3'b000) begin
         fail_count++;
         $display("[TB] FAIL lw_memadr: strobes=%b a=%b b=%b imm=%b, required 00000/10/01/000", strobes, ALUSrcA, ALUSrcB, ImmSrc);
      end
      advance(); settle();
      assert_count++;
      if (strobes !== 5'b10000 || AdrSrc !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL lw_memread: strobes=%b adr=%b, required 10000/1", strobes, AdrSrc);
      end
      advance(); settle();
      assert_count++;
      if (strobes !== 5'b00001 || ResultSrc !== 2'b01) begin
         fail_count++;
         $display("[TB] FAIL lw_memwb: strobes=%b res=%b, required 00001/01", strobes, ResultSrc);
      end
      advance(); settle();
      assert_count++;
      if (strobes !== 5'b10110 || instret !== 32'd1) begin
         fail_count++;
         $display("[TB] FAIL lw_next_fetch: strobes=%b instret=%0d, required 10110/1", strobes, instret);
      end
   endtask

   task automatic test_r_alu();
      do_reset();
      op = 7'b0110011;
      funct3 = 3'b000;
      funct7b5 = 1'b0;
      mem_ready = 1'b1;
      advance(); advance();
      settle();
      assert_count++;
      if (ALUControl !== 3'b000 || strobes !== 5'b00000) begin
         fail_count++;
         $display("[TB] FAIL add_exec: alu=%b strobes=%b, required 000/00000", ALUControl, strobes);
      end
      advance(); settle();
      assert_count++;
      if (strobes !== 5'b00001) begin
         fail_count++;
         $display("[TB] FAIL add_aluwb: strobes=%b, required 00001", strobes);
      end
      advance();
      funct7b5 = 1'b1;
      settle();
      assert_count++;
      if (instret !== 32'd1 || strobes !== 5'b10110) begin
         fail_count++;
         $display("[TB] FAIL add_retire: instret=%0d strobes=%b, required 1/10110", instret, strobes);
      end
      advance(); advance();
      settle();
      assert_count++;
      if (ALUControl !== 3'b001) begin
         fail_count++;
         $display("[TB] FAIL sub_exec: alu=%b, required 001", ALUControl);
      end
      advance(); advance();
      settle();
      assert_count++;
      if (instret !== 32'd2) begin
         fail_count++;
         $display("[TB] FAIL sub_retire: instret=%0d, required 2", instret);
      end
   endtask

   task automatic test_branch();
      for (int bne = 0; bne < 2; bne++) begin
         for (int z = 0; z < 2; z++) begin
            logic exp_pc;
            exp_pc = (z != 0) ^ (bne != 0);
            do_reset();
            op = 7'b1100011;
            funct3 = (bne != 0) ? 3'b001 : 3'b000;
            Zero = (z != 0);
            mem_ready = 1'b1;
            advance(); advance();
            settle();
            assert_count++;
            if (strobes !== {3'b000, exp_pc, 1'b0} || ALUControl !== 3'b001) begin
               fail_count++;
               $display("[TB] FAIL branch bne=%0d zero=%0d: strobes=%b alu=%b, required %b/001", bne, z, strobes, ALUControl, {3'b000, exp_pc, 1'b0});
            end
            advance(); settle();
            assert_count++;
            if (instret !== 32'd1 || mem_req !== 1'b1) begin
               fail_count++;
               $display("[TB] FAIL branch_retire bne=%0d zero=%0d: instret=%0d mem_req=%b, required 1/1", bne, z, instret, mem_req);
            end
         end
      end
   endtask

   task automatic test_illegal();
      do_reset();
      op = 7'b1111111;
      mem_ready = 1'b1;
      advance(); settle();
      assert_count++;
      if (trap !== 1'b0 || strobes !== 5'b00000) begin
         fail_count++;
         $display("[TB] FAIL illegal_decode: trap=%b strobes=%b, required 0/00000", trap, strobes);
      end
      advance();
      for (int k = 0; k < 20; k++) begin
         mem_ready = 1'($urandom_range(0, 1));
         Zero = 1'($urandom_range(0, 1));
         settle();
         assert_count++;
         if (trap !== 1'b1 || trap_cause !== 2'b01 || strobes !== 5'b00000 || instret !== 32'd0) begin
            fail_count++;
            $display("[TB] FAIL illegal_hold cycle %0d: trap=%b cause=%b strobes=%b instret=%0d, required 1/01/00000/0", k, trap, trap_cause, strobes, instret);
         end
         advance();
      end
   endtask

   task automatic test_timeout();
      do_reset();
      op = 7'b0110011;
      mem_ready = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         settle();
         assert_count++;
         if (mem_req !== 1'b1 || trap !== 1'b0) begin
            fail_count++;
            $display("[TB] FAIL timeout_wait %0d: mem_req=%b trap=%b, required 1/0", k, mem_req, trap);
         end
         advance();
      end
      settle();
      assert_count++;
      if (trap !== 1'b1 || trap_cause !== 2'b10 || strobes !== 5'b00000) begin
         fail_count++;
         $display("[TB] FAIL timeout_trap: trap=%b cause=%b strobes=%b, required 1/10/00000", trap, trap_cause, strobes);
      end
      do_reset();
      op = 7'b0110011;
      repeat (14) advance();
      mem_ready = 1'b1;
      settle();
      assert_count++;
      if (IRWrite !== 1'b1 || trap !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL ready_15th: IRWrite=%b trap=%b, required 1/0", IRWrite, trap);
      end
      advance();
      mem_ready = 1'b0;
      advance(); advance(); advance();
      repeat (15) advance();
      settle();
      assert_count++;
      if (trap !== 1'b0 || instret !== 32'd1 || mem_req !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL counter_clears: trap=%b instret=%0d mem_req=%b, required 0/1/1", trap, instret, mem_req);
      end
   endtask

   task automatic test_reset_mid_store();
      do_reset();
      op = 7'b0110011;
      funct3 = 3'b000;
      mem_ready = 1'b1;
      repeat (4) advance();
      op = 7'b0100011;
      funct3 = 3'b010;
      advance();
      mem_ready = 1'b0;
      advance(); advance();
      settle();
      assert_count++;
      if (strobes !== 5'b11000 || AdrSrc !== 1'b1 || instret !== 32'd1) begin
         fail_count++;
         $display("[TB] FAIL store_wait: strobes=%b adr=%b instret=%0d, required 11000/1/1", strobes, AdrSrc, instret);
      end
      advance();
      #1 rst = 1'b0;
      #1;
      assert_count++;
      if (mem_req !== 1'b0 || MemWrite !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL store_reset_drop: mem_req=%b MemWrite=%b, required 0/0", mem_req, MemWrite);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      settle();
      assert_count++;
      if (strobes !== 5'b10000 || instret !== 32'd0 || trap !== 1'b0) begin
         fail_count++;
         $display("[TB] FAIL store_after_reset: strobes=%b instret=%0d trap=%b, required 10000/0/0", strobes, instret, trap);
      end
   endtask

   function automatic cyc_t blank();
      cyc_t c;
      c.ready = 1'($urandom_range(0, 1));
      c.strb = 5'b00000;
      c.chk_alu = 0; c.alu = '0;
      c.chk_sel = 0; c.sel = '0;
      c.chk_imm = 0; c.imm = '0;
      c.chk_res = 0; c.res = '0;
      c.chk_adr = 0; c.adr = 1'b0;
      c.chk_ret = 0; c.ret = '0;
      return c;
   endfunction

   // Random legal instructions with random memory waits; each instruction expands to its phase list
   task automatic test_random();
      cyc_t q[$];
      cyc_t c;
      int   retired = 0;
      int   kind, sub, waits;
      logic [2:0] exp_alu;
      logic exp_pc;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         q.delete();
         kind = $urandom_range(0, 6);
         funct7b5 = 1'b0;
         Zero = 1'($urandom_range(0, 1));
         exp_alu = 3'b000;
         exp_pc = 1'b0;
         case (kind)
            0: begin op = 7'b0000011; funct3 = 3'b010; end
            1: begin op = 7'b0100011; funct3 = 3'b010; end
            2: begin
               op = 7'b0110011;
               sub = $urandom_range(0, 4);
               case (sub)
                  0: begin funct3 = 3'b000; exp_alu = 3'b000; end
                  1: begin funct3 = 3'b000; funct7b5 = 1'b1; exp_alu = 3'b001; end
                  2: begin funct3 = 3'b010; exp_alu = 3'b101; end
                  3: begin funct3 = 3'b110; exp_alu = 3'b011; end
                  default: begin funct3 = 3'b111; exp_alu = 3'b010; end
               endcase
            end
            3: begin
               op = 7'b0010011;
               funct7b5 = 1'($urandom_range(0, 1));
               sub = $urandom_range(0, 3);
               case (sub)
                  0: begin funct3 = 3'b000; exp_alu = 3'b000; end
                  1: begin funct3 = 3'b010; exp_alu = 3'b101; end
                  2: begin funct3 = 3'b110; exp_alu = 3'b011; end
                  default: begin funct3 = 3'b111; exp_alu = 3'b010; end
               endcase
            end
            4: begin
               op = 7'b1100011;
               sub = $urandom_range(0, 1);
               funct3 = (sub != 0) ? 3'b001 : 3'b000;
               exp_pc = Zero ^ (sub != 0);
            end
            5: begin op = 7'b1101111; funct3 = 3'($urandom_range(0, 7)); end
            default: begin op = 7'b0110111; funct3 = 3'($urandom_range(0, 7)); end
         endcase
         waits = $urandom_range(0, 3);
         for (int w = 0; w <= waits; w++) begin
            c = blank();
            c.ready = (w == waits);
            c.strb = (w == waits) ? 5'b10110 : 5'b10000;
            c.chk_alu = 1; c.alu = 3'b000;
            c.chk_sel = 1; c.sel = 4'b0010;
            c.chk_res = 1; c.res = 2'b10;
            c.chk_adr = 1; c.adr = 1'b0;
            c.chk_ret = 1; c.ret = 32'(retired);
            q.push_back(c);
         end
         c = blank();
         c.chk_alu = 1; c.alu = 3'b000;
         c.chk_sel = 1; c.sel = 4'b0101;
         c.chk_imm = 1; c.imm = 3'b010;
         q.push_back(c);
         case (kind)
            0, 1: begin
               c = blank();
               c.chk_alu = 1; c.alu = 3'b000;
               c.chk_sel = 1; c.sel = 4'b1001;
               c.chk_imm = 1; c.imm = (kind == 0) ? 3'b000 : 3'b001;
               q.push_back(c);
               waits = $urandom_range(0, 3);
               for (int w = 0; w <= waits; w++) begin
                  c = blank();
                  c.ready = (w == waits);
                  c.strb = (kind == 0) ? 5'b10000 : 5'b11000;
                  c.chk_adr = 1; c.adr = 1'b1;
                  q.push_back(c);
               end
               if (kind == 0) begin
                  c = blank();
                  c.strb = 5'b00001;
                  c.chk_res = 1; c.res = 2'b01;
                  q.push_back(c);
               end
            end
            2, 3, 6: begin
               c = blank();
               c.chk_alu = 1; c.alu = exp_alu;
               c.chk_sel = 1;
               c.sel = (kind == 2) ? 4'b1000 : (kind == 3) ? 4'b1001 : 4'b1101;
               c.chk_imm = (kind != 2);
               c.imm = (kind == 6) ? 3'b100 : 3'b000;
               q.push_back(c);
               c = blank();
               c.strb = 5'b00001;
               c.chk_res = 1; c.res = 2'b00;
               q.push_back(c);
            end
            4: begin
               c = blank();
               c.strb = {3'b000, exp_pc, 1'b0};
               c.chk_alu = 1; c.alu = 3'b001;
               c.chk_sel = 1; c.sel = 4'b1000;
               c.chk_res = 1; c.res = 2'b00;
               q.push_back(c);
            end
            default: begin
               c = blank();
               c.strb = 5'b00011;
               c.chk_alu = 1; c.alu = 3'b000;
               c.chk_sel = 1; c.sel = 4'b0110;
               c.chk_imm = 1; c.imm = 3'b011;
               c.chk_res = 1; c.res = 2'b00;
               q.push_back(c);
            end
         endcase
         for (int i = 0; i < q.size(); i++) begin
            c = q[i];
            mem_ready = c.ready;
            settle();
            assert_count++;
            if (strobes !== c.strb ||
                (c.chk_alu && ALUControl !== c.alu) ||
                (c.chk_sel && {ALUSrcA, ALUSrcB} !== c.sel) ||
                (c.chk_imm && ImmSrc !== c.imm) ||
                (c.chk_res && ResultSrc !== c.res) ||
                (c.chk_adr && AdrSrc !== c.adr) ||
                (c.chk_ret && instret !== c.ret) ||
                trap !== 1'b0) begin
               fail_count++;
               $display("[TB] FAIL random instr %0d kind %0d cycle %0d: strb=%b alu=%b sel=%b imm=%b res=%b adr=%b ret=%0d trap=%b, required strb=%b alu=%b sel=%b imm=%b res=%b adr=%b ret=%0d trap=0",
                        n, kind, i, strobes, ALUControl, {ALUSrcA, ALUSrcB}, ImmSrc, ResultSrc, AdrSrc, instret, trap,
                        c.strb, c.alu, c.sel, c.imm, c.res, c.adr, c.ret);
            end
            advance();
         end
         retired++;
      end
      settle();
      assert_count++;
      if (instret !== 32'(retired) || strobes[4] !== 1'b1) begin
         fail_count++;
         $display("[TB] FAIL random_final: instret=%0d mem_req=%b, required %0d/1", instret, strobes[4], retired);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset();
      test_lw();
      test_r_alu();
      test_branch();
      test_illegal();
      test_timeout();
      test_reset_mid_store();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
